sysarray_skew_feeder: RTL and testbench

//  Operand transmitter for the NxN systolic array: buffers matrix A (N x K) and B (K x N), then drives
//  the array's west and north edges with diagonally skewed streams so PE(i,j) sees A[i][k]/B[k][j] aligned.

---
 rtl/sysarray_skew_feeder_if.sv | 31 +++
 rtl/sysarray_skew_feeder.sv | 135 +++++++++++++
 tb/tb_sysarray_skew_feeder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sysarray_skew_feeder_if.sv
// Host-side bus of the systolic-array operand feeder: operand writes, start/status, and skewed edge streams.
interface sysarray_skew_feeder_if #(
  parameter int N  = 16,
  parameter int K  = 16,
  parameter int DW = 32
) ();
  localparam int MX = (N > K) ? N : K;
  localparam int AW = (MX > 1) ? $clog2(MX) : 1;

  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_r;
  logic [AW-1:0]   wr_c;
  logic [DW-1:0]   wr_data;
  logic            wr_err;
  logic            start;
  logic            busy;
  logic            done;
  logic            out_valid;
  logic [N*DW-1:0] west_o;
  logic [N*DW-1:0] north_o;

  modport master (
    output wr_en, wr_sel, wr_r, wr_c, wr_data, start,
    input  wr_err, busy, done, out_valid, west_o, north_o
  );
  modport slave (
    input  wr_en, wr_sel, wr_r, wr_c, wr_data, start,
    output wr_err, busy, done, out_valid, west_o, north_o
  );
endinterface

// File: rtl/sysarray_skew_feeder.sv
// Buffers A (NxK) and B (KxN) and streams them diagonally skewed onto the array's west/north edges.
// Optional SKEW_FEEDER_ACC_CLR_EN adds acc_clr, high alongside the first (t=0) slice.
module sysarray_skew_lane #(
  parameter int LEN = 16,
  parameter int DW  = 32,
  parameter int CW  = 6,
  parameter int IDX = 0
) (
  input  logic [CW-1:0]            t,
  input  logic [LEN-1:0][DW-1:0]   vec,
  output logic [DW-1:0]            val
);
  localparam int LW = (LEN > 1) ? $clog2(LEN) : 1;
  logic [CW:0] k;

  // lane IDX lags the slice counter by IDX cycles; outside the window it emits zero
  always_comb begin
    k   = {1'b0, t} - (CW+1)'(IDX);
    val = '0;
    if (({1'b0, t} >= (CW+1)'(IDX)) && (k < (CW+1)'(LEN)))
      val = vec[k[LW-1:0]];
  end
endmodule

module sysarray_skew_feeder #(
  parameter int N  = 16,
  parameter int K  = 16,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst,
  sysarray_skew_feeder_if.slave bus
`ifdef SKEW_FEEDER_ACC_CLR_EN
  ,
  output logic acc_clr
`endif
);
  localparam int MX = (N > K) ? N : K;
  localparam int AW = (MX > 1) ? $clog2(MX) : 1;
  localparam int NI = (N > 1) ? $clog2(N) : 1;
  localparam int KI = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(K + 2*N);
  localparam logic [CW-1:0] LAST_T  = CW'(K + N - 2);
  localparam logic [CW-1:0] FLUSH_T = CW'(2*N - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                  state;
  logic [CW-1:0]               t, t_nxt;
  logic [N-1:0][K-1:0][DW-1:0] a_mem;   // [row][k]
  logic [N-1:0][K-1:0][DW-1:0] b_mem;   // [col][k], column-major so each north lane reads one row
  logic [N-1:0][K-1:0][DW-1:0] a_fwd, b_fwd;
  logic [N-1:0][DW-1:0]        west_nx, north_nx, west_q, north_q;
  logic                        in_rng, wr_ok, wr_err_q;

  assign in_rng = bus.wr_sel ? (({1'b0, bus.wr_r} < (AW+1)'(K)) && ({1'b0, bus.wr_c} < (AW+1)'(N)))
                             : (({1'b0, bus.wr_r} < (AW+1)'(N)) && ({1'b0, bus.wr_c} < (AW+1)'(K)));
  assign wr_ok  = bus.wr_en && (state == S_IDLE) && in_rng;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (!bus.wr_sel) a_mem[bus.wr_r[NI-1:0]][bus.wr_c[KI-1:0]] <= bus.wr_data;
      else             b_mem[bus.wr_c[NI-1:0]][bus.wr_r[KI-1:0]] <= bus.wr_data;
    end
  end

  // slice 0 touches only element [0][0]; forward a same-edge write so write-then-start ordering holds
  always_comb begin
    a_fwd = a_mem;
    b_fwd = b_mem;
    if (wr_ok && (bus.wr_r == '0) && (bus.wr_c == '0)) begin
      if (!bus.wr_sel) a_fwd[0][0] = bus.wr_data;
      else             b_fwd[0][0] = bus.wr_data;
    end
  end

  assign t_nxt = (state == S_FEED) ? t + CW'(1) : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sysarray_skew_lane #(.LEN(K), .DW(DW), .CW(CW), .IDX(i)) u_west (
      .t(t_nxt), .vec(a_fwd[i]), .val(west_nx[i]));
    sysarray_skew_lane #(.LEN(K), .DW(DW), .CW(CW), .IDX(i)) u_north (
      .t(t_nxt), .vec(b_fwd[i]), .val(north_nx[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      t        <= '0;
      west_q   <= '0;
      north_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
      case (state)
        S_IDLE: if (bus.start) begin
          state   <= S_FEED;
          t       <= '0;
          west_q  <= west_nx;
          north_q <= north_nx;
        end
        S_FEED: if (t == LAST_T) begin
          state   <= S_FLUSH;
          t       <= '0;
          west_q  <= '0;
          north_q <= '0;
        end else begin
          t       <= t + CW'(1);
          west_q  <= west_nx;
          north_q <= north_nx;
        end
        S_FLUSH: if (t == FLUSH_T) begin
          state <= S_DONE;
          t     <= '0;
        end else begin
          t     <= t + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_err    = wr_err_q;
  assign bus.busy      = (state == S_FEED) || (state == S_FLUSH);
  assign bus.done      = (state == S_DONE);
  assign bus.out_valid = (state == S_FEED);
  assign bus.west_o    = west_q;
  assign bus.north_o   = north_q;
`ifdef SKEW_FEEDER_ACC_CLR_EN
  assign acc_clr = (state == S_FEED) && (t == '0);
`endif
endmodule

// File: tb/tb_sysarray_skew_feeder.sv
// Directed bench for the skew feeder at N=2, K=3: skew pattern, flush, done, write rejection, mid-run reset.
module tb_sysarray_skew_feeder;
  logic clk, rst;
  int   vec, miss;
`ifdef SKEW_FEEDER_ACC_CLR_EN
  logic acc_clr;
`endif

  sysarray_skew_feeder_if #(.N(2), .K(3), .DW(32)) bus ();

  sysarray_skew_feeder #(.N(2), .K(3), .DW(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef SKEW_FEEDER_ACC_CLR_EN
    , .acc_clr(acc_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected edge streams for A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]]
  logic [31:0] w0 [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
  logic [31:0] w1 [4] = '{32'd0, 32'd4, 32'd5, 32'd6};
  logic [31:0] n0 [4] = '{32'd7, 32'd9, 32'd11, 32'd0};
  logic [31:0] n1 [4] = '{32'd0, 32'd8, 32'd10, 32'd12};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input int r, input int c, input int d);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_r = 2'(r); bus.wr_c = 2'(c); bus.wr_data = 32'(d);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  // caller raises start (time just after an edge); checks the whole FEED/FLUSH/DONE sequence
  task automatic run_seq(input bit stray);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      bus.start = stray && (c == 1);
      chk($sformatf("feed%0d_west", c),  bus.west_o,  {w1[c], w0[c]});
      chk($sformatf("feed%0d_north", c), bus.north_o, {n1[c], n0[c]});
      chk($sformatf("feed%0d_flags", c), {bus.out_valid, bus.busy, bus.done}, 3'b110);
`ifdef SKEW_FEEDER_ACC_CLR_EN
      chk($sformatf("feed%0d_acc_clr", c), acc_clr, (c == 0));
`endif
    end
    for (int f = 0; f < 3; f++) begin
      @(posedge clk); #1;
      bus.start = stray && (f == 1);
      chk($sformatf("flush%0d_data", f), {bus.west_o, bus.north_o} == '0, 1'b1);
      chk($sformatf("flush%0d_flags", f), {bus.out_valid, bus.busy, bus.done}, 3'b010);
`ifdef SKEW_FEEDER_ACC_CLR_EN
      chk($sformatf("flush%0d_acc_clr", f), acc_clr, 1'b0);
`endif
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_flags", {bus.out_valid, bus.busy, bus.done}, 3'b001);
    @(posedge clk); #1;
    chk("idle_flags", {bus.out_valid, bus.busy, bus.done}, 3'b000);
  endtask

  initial begin
    logic seen;
    vec = 0; miss = 0;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_r = '0; bus.wr_c = '0; bus.wr_data = '0;
    bus.start = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_data",  {bus.west_o, bus.north_o} == '0, 1'b1);
    chk("rst_flags", {bus.out_valid, bus.busy, bus.done, bus.wr_err}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // load; A[0][0] deliberately wrong, corrected on the start edge
    wr(0, 0, 0, 5); wr(0, 0, 1, 2); wr(0, 0, 2, 3);
    wr(0, 1, 0, 4); wr(0, 1, 1, 5); wr(0, 1, 2, 6);
    wr(1, 0, 0, 7); wr(1, 0, 1, 8); wr(1, 1, 0, 9);
    wr(1, 1, 1, 10); wr(1, 2, 0, 11); wr(1, 2, 1, 12);
    chk("load_no_err", bus.wr_err, 1'b0);

    // test 1: write and start on the same edge
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_r = 2'd0; bus.wr_c = 2'd0; bus.wr_data = 32'd1;
    bus.start = 1'b1;
    run_seq(1'b0);

    // test 2: stray start during FEED and FLUSH
    bus.start = 1'b1;
    run_seq(1'b1);

    // test 3: write while busy, then out-of-range writes in IDLE
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_r = 2'd0; bus.wr_c = 2'd0; bus.wr_data = 32'd99;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk("busy_wr_err", bus.wr_err, 1'b1);
    @(posedge clk); #1;
    chk("busy_wr_err_clear", bus.wr_err, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    chk("t3_done_seen", seen, 1'b1);
    @(posedge clk); #1;
    wr(0, 2, 0, 99);
    chk("a_row_oor_err", bus.wr_err, 1'b1);
    wr(1, 0, 2, 99);
    chk("b_col_oor_err", bus.wr_err, 1'b1);
    wr(0, 1, 2, 6);
    chk("edge_index_ok", bus.wr_err, 1'b0);
    bus.start = 1'b1;
    run_seq(1'b0);

    // test 4: reset in FEED cycle 2
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t4_slice2_west",  bus.west_o,  {32'd5, 32'd3});
    chk("t4_slice2_north", bus.north_o, {32'd10, 32'd11});
    rst = 1'b1;
    #1;
    chk("t4_rst_data",  {bus.west_o, bus.north_o} == '0, 1'b1);
    chk("t4_rst_flags", {bus.out_valid, bus.busy, bus.done}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("t4_no_done", seen, 1'b0);
    bus.start = 1'b1;
    run_seq(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
